mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_rr_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// The lock feature is enabled by the MEM_ARBITER_LOCK_EN macro in mem_arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    RWAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam int MAX_READ_LAT = 4;
  // Counter only ever holds READ_LAT-1, so log2 of the maximum is enough
  localparam int CNT_W = $clog2(MAX_READ_LAT);

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin pick between two requesters. Under contention the
// master not granted last wins, unless lock keeps M1 on top after an M1 grant.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_t    last,
  input  logic       lock,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == M1 && !lock) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two masters with
// one read in flight at a time. Define MEM_ARBITER_LOCK_EN to add the m1_lock input.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic          m1_lock,
`endif
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  master_t          owner_q, owner_d;
  master_t          last_q, last_d;
  logic [1:0]       rvalid_q;
  logic [DW-1:0]    rdata0_q, rdata1_q;
  logic [1:0]       req_v, gnt_v;
  logic             lock_v, sel_we, capture;
  master_t          sel;

`ifdef MEM_ARBITER_LOCK_EN
  assign lock_v = m1_lock;
`else
  assign lock_v = 1'b0;
`endif

  assign req_v  = (state_q == IDLE) ? {m1_req, m0_req} : 2'b00;
  assign sel    = gnt_v[1] ? M1 : M0;
  assign sel_we = gnt_v[1] ? m1_we : m0_we;

  mem_arb_rr_pick u_pick (
    .req  (req_v),
    .last (last_q),
    .lock (lock_v),
    .gnt  (gnt_v)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= M0;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt_v) begin
          last_d = sel;
          if (!sel_we) begin
            state_d = RWAIT;
            cnt_d   = CNT_W'(READ_LAT - 1);
            owner_d = sel;
          end
        end
      end
      RWAIT: begin
        // Leaving on the capture cycle lets a new grant overlap the rvalid pulse
        if (cnt_q == '0) begin
          state_d = IDLE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_gnt    = gnt_v[0];
    m1_gnt    = gnt_v[1];
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_v[0]) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt_v[1]) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= 2'b00;
      if (capture) begin
        if (owner_q == M1) begin
          rvalid_q <= 2'b10;
          rdata1_q <= mem_rdata;
        end else begin
          rvalid_q <= 2'b01;
          rdata0_q <= mem_rdata;
        end
      end
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a cycle-count based reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
`ifdef MEM_ARBITER_LOCK_EN
  logic m1_lock = 1'b0;
`endif
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(RL)) u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
`ifdef MEM_ARBITER_LOCK_EN
    .m1_lock   (m1_lock),
`endif
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'hDEADBEEF : {16'hC0DE, 8'(i), 8'(255 - i)};
  endfunction

  // Memory model: word-indexed by addr[9:2], read data READ_LAT cycles after address
  logic [31:0] mem_arr [256];
  logic [31:0] pipe [RL];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
    end else if (mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
    pipe[0] <= mem_addr;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = mem_arr[pipe[RL-1][9:2]];

  // Reference model state
  logic [31:0] ref_mem [256];
  int cyc = 0;
  int busy_until = 0;
  int rv_cycle = -1;
  logic rv_who = 1'b0;
  logic [31:0] rv_data = '0;
  logic last_m1 = 1'b1;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
  logic [31:0] wd [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".m0_gnt"}, 32'(m0_gnt), 32'd0);
    chk({tag, ".m1_gnt"}, 32'(m1_gnt), 32'd0);
    chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    chk({tag, ".m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, ".m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic model_reset();
    busy_until = cyc;
    rv_cycle = -1;
    last_m1 = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // Called at a falling edge with this cycle's inputs already driven
  task automatic step();
    logic [1:0] g;
    logic [1:0] rv;
    logic lk, we_s;
    logic [31:0] a_s, d_s;
    #1;
    lk = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
    lk = m1_lock;
`endif
    g = 2'b00;
    if (cyc >= busy_until) begin
      if (m0_req && m1_req) g = (last_m1 && !lk) ? 2'b01 : 2'b10;
      else g = {m1_req, m0_req};
    end
    rv = 2'b00;
    if (rv_cycle == cyc) begin
      rv = rv_who ? 2'b10 : 2'b01;
      if (rv_who) exp_rd1 = rv_data;
      else exp_rd0 = rv_data;
    end
    we_s = 1'b0; a_s = '0; d_s = '0;
    if (g[0]) begin we_s = m0_we; a_s = m0_addr; d_s = m0_wdata; end
    else if (g[1]) begin we_s = m1_we; a_s = m1_addr; d_s = m1_wdata; end
    chk("m0_gnt", 32'(m0_gnt), 32'(g[0]));
    chk("m1_gnt", 32'(m1_gnt), 32'(g[1]));
    chk("mem_we", 32'(mem_we), 32'(we_s));
    chk("mem_addr", mem_addr, a_s);
    chk("mem_wdata", mem_wdata, d_s);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(rv[1]));
    chk("m0_rdata", m0_rdata, exp_rd0);
    chk("m1_rdata", m1_rdata, exp_rd1);
    if (g != 2'b00) begin
      last_m1 = g[1];
      if (we_s) begin
        ref_mem[a_s[9:2]] = d_s;
      end else begin
        busy_until = cyc + RL + 1;
        rv_cycle = busy_until;
        rv_who = g[1];
        rv_data = ref_mem[a_s[9:2]];
      end
    end
    @(negedge clk);
    cyc++;
    if (g[0]) m0_req = 1'b0;
    if (g[1]) m1_req = 1'b0;
  endtask

  task automatic set_m0(input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic we, input logic [31:0] a, input logic [31:0] d);
    m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'(4 * $urandom_range(0, 63));
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");

    // Single read of 0x100
    @(negedge clk);
    rst_n = 1'b1;
    set_m0(1'b0, 32'h100, 32'h0);
    repeat (RL + 3) step();
    chk("single_rdata", m0_rdata, 32'hDEADBEEF);

    // Contention: both masters keep issuing reads
    for (int c = 0; c < 6 * (RL + 1); c++) begin
      if (!m0_req) set_m0(1'b0, rand_addr(), 32'h0);
      if (!m1_req) set_m1(1'b0, rand_addr(), 32'h0);
      step();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (RL + 2) step();

    // M1 write stream 0x200..0x20C on consecutive cycles
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom();
      set_m1(1'b1, 32'h200 + 32'(4 * k), wd[k]);
      step();
    end
    step();
    for (int k = 0; k < 4; k++) chk("wstream_mem", mem_arr[128 + k], wd[k]);

    // M1 waits while an M0 read is in flight
    set_m0(1'b0, 32'h104, 32'h0);
    step();
    set_m1(1'b1, 32'h300, 32'h5A5A_0001);
    repeat (RL + 3) step();

    // Reset one cycle after a read grant discards the read
    set_m0(1'b0, 32'h108, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (RL + 4) step();

`ifdef MEM_ARBITER_LOCK_EN
    // Burst lock keeps M1 on top, then release hands the next grant to M0
    set_m1(1'b1, 32'h310, 32'h1);
    step();
    m1_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!m0_req) set_m0(1'b1, 32'h320, 32'h2);
      if (!m1_req) set_m1(1'b1, 32'h330 + 32'(4 * k), 32'(k));
      step();
    end
    m1_lock = 1'b0;
    if (!m0_req) set_m0(1'b1, 32'h320, 32'h2);
    if (!m1_req) set_m1(1'b1, 32'h340, 32'h3);
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
`endif

    // Random traffic with occasional withdrawn requests
    for (int c = 0; c < 400; c++) begin
      if (!m0_req && 1'($urandom_range(0, 1))) set_m0(1'($urandom_range(0, 1)), rand_addr(), $urandom());
      else if (m0_req && $urandom_range(0, 15) == 0) m0_req = 1'b0;
      if (!m1_req && 1'($urandom_range(0, 1))) set_m1(1'($urandom_range(0, 1)), rand_addr(), $urandom());
      else if (m1_req && $urandom_range(0, 15) == 0) m1_req = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
      m1_lock = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (RL + 3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
